uart_rx_assembler: RTL and testbench

//   Upstream stage of the UART sender. Collects NBYTES bytes from uart_rx into one wide word, first byte in the MSB.

---
 rtl/uart_pkg.sv | 18 +
 rtl/rx_idle_timer.sv | 29 ++
 rtl/uart_rx_assembler.sv | 161 ++++++++++++++++
 tb/tb_uart_rx_assembler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: assembler state encoding and the bit-timing helper
// used by uart_tx, uart_rx and uart_rx_assembler.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_HOLD    = 2'd2
  } rxAsmState_t;

  // Clock cycles per 10-bit UART character (start + 8 data + stop).
  function automatic int byteCycles(input int clkFreq, input int baudRate);
    longint cyc;
    cyc = (longint'(clkFreq) * 64'sd10) / longint'(baudRate);
    return int'(cyc);
  endfunction

endpackage

// File: rtl/rx_idle_timer.sv
// Idle-gap timer: counts enabled cycles since the last clear and flags the
// cycle in which the count sits at TMO_CYC-1 while still enabled.
module rx_idle_timer #(
  parameter int TMO_CYC = 400
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iClear,
  input  logic iEnable,
  output logic oTerm
);

  localparam int TW = $clog2(TMO_CYC + 1);
  localparam logic [TW-1:0] TERM = TW'(TMO_CYC - 1);

  logic [TW-1:0] rCount;

  // Saturates at TERM so a stalled consumer of oTerm can never see a wrap.
  always_ff @(posedge iClk) begin
    if (iRst || iClear) begin
      rCount <= '0;
    end else if (iEnable && (rCount != TERM)) begin
      rCount <= rCount + 1'b1;
    end
  end

  assign oTerm = iEnable && (rCount == TERM);

endmodule

// File: rtl/uart_rx_assembler.sv
// Packs NBYTES received UART bytes (first byte in the MSBs) into one word and
// offers it downstream; a partial frame is dropped after an idle timeout.
module uart_rx_assembler
  import uart_pkg::*;
#(
  parameter int NBYTES        = 32,
  parameter int CLK_FREQ      = 125_000_000,
  parameter int BAUD_RATE     = 115_200,
  parameter int TIMEOUT_BYTES = 4
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic [7:0]          iRxByte,
  input  logic                iRxDone,
  output logic [NBYTES*8-1:0] oData,
  output logic                oValid,
  input  logic                iReady,
  output logic                oBusy,
  output logic                oTimeout,
  output logic                oOverrun,
  output logic [1:0]          oState
);

  localparam int W        = NBYTES * 8;
  localparam int BYTE_CYC = byteCycles(CLK_FREQ, BAUD_RATE);
  localparam int TMO_CYC  = TIMEOUT_BYTES * BYTE_CYC;
  localparam int CW       = $clog2(NBYTES + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  // Handshake: a frame moves on every rising edge where oValid && iReady;
  // oData and oValid stay unchanged until that edge.

  rxAsmState_t   state, nextState;
  logic [W-1:0]  rBuf, nextBuf;
  logic [W-1:0]  rData, nextData;
  logic [CW-1:0] rCnt, nextCnt;
  logic          rTimeout, nextTimeout;
  logic          rOverrun, nextOverrun;

  logic [W-1:0]  shifted;
  logic [W-1:0]  byteZext;
  logic          timerEn;
  logic          timerClear;
  logic          timerTerm;

  assign byteZext = W'(iRxByte);

  generate
    if (NBYTES == 1) begin : gSingle
      assign shifted = byteZext;
    end else begin : gMulti
      assign shifted = {rBuf[W-9:0], iRxByte};
    end
  endgenerate

  assign timerEn    = (state == S_COLLECT) && !iRxDone;
  assign timerClear = !timerEn;

  rx_idle_timer #(
    .TMO_CYC(TMO_CYC)
  ) uTimer (
    .iClk   (iClk),
    .iRst   (iRst),
    .iClear (timerClear),
    .iEnable(timerEn),
    .oTerm  (timerTerm)
  );

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state    <= S_IDLE;
      rBuf     <= '0;
      rData    <= '0;
      rCnt     <= '0;
      rTimeout <= 1'b0;
      rOverrun <= 1'b0;
    end else begin
      state    <= nextState;
      rBuf     <= nextBuf;
      rData    <= nextData;
      rCnt     <= nextCnt;
      rTimeout <= nextTimeout;
      rOverrun <= nextOverrun;
    end
  end

  always_comb begin
    nextState   = state;
    nextBuf     = rBuf;
    nextData    = rData;
    nextCnt     = rCnt;
    nextTimeout = 1'b0;
    nextOverrun = 1'b0;
    case (state)
      S_IDLE: begin
        if (iRxDone) begin
          if (NBYTES == 1) begin
            nextData  = byteZext;
            nextBuf   = '0;
            nextCnt   = '0;
            nextState = S_HOLD;
          end else begin
            nextBuf   = byteZext;
            nextCnt   = ONE;
            nextState = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        if (iRxDone) begin
          if (rCnt == LAST_IDX) begin
            nextData  = shifted;
            nextBuf   = '0;
            nextCnt   = '0;
            nextState = S_HOLD;
          end else begin
            nextBuf = shifted;
            nextCnt = rCnt + 1'b1;
          end
        end else if (timerTerm) begin
          nextTimeout = 1'b1;
          nextBuf     = '0;
          nextCnt     = '0;
          nextState   = S_IDLE;
        end
      end
      S_HOLD: begin
        if (iReady) begin
          nextState = S_IDLE;
          // A byte landing on the handshake edge opens the next frame.
          if (iRxDone) begin
            if (NBYTES == 1) begin
              nextData  = byteZext;
              nextState = S_HOLD;
            end else begin
              nextBuf   = byteZext;
              nextCnt   = ONE;
              nextState = S_COLLECT;
            end
          end
        end else if (iRxDone) begin
          nextOverrun = 1'b1;
        end
      end
      default: begin
        nextState = S_IDLE;
        nextBuf   = '0;
        nextCnt   = '0;
      end
    endcase
  end

  assign oData    = rData;
  assign oValid   = (state == S_HOLD);
  assign oBusy    = (state == S_COLLECT);
  assign oTimeout = rTimeout;
  assign oOverrun = rOverrun;
  assign oState   = state;

endmodule

// File: tb/tb_uart_rx_assembler.sv
// Directed bench for uart_rx_assembler with NBYTES=4, BYTE_CYC=100, TMO_CYC=400.
module tb_uart_rx_assembler;

  typedef struct {
    logic [31:0] bytes;
    int          gap;
    int          hold;
    logic [31:0] expWord;
  } vec_t;

  logic        iClk;
  logic        iRst;
  logic [7:0]  iRxByte;
  logic        iRxDone;
  logic [31:0] oData;
  logic        oValid;
  logic        iReady;
  logic        oBusy;
  logic        oTimeout;
  logic        oOverrun;
  logic [1:0]  oState;

  int checks = 0;
  int errors = 0;
  int timeoutCnt = 0;
  int overrunCnt = 0;
  logic [31:0] exp_q[$];
  vec_t vecs[5];

  uart_rx_assembler #(
    .NBYTES       (4),
    .CLK_FREQ     (1_000_000),
    .BAUD_RATE    (100_000),
    .TIMEOUT_BYTES(4)
  ) dut (
    .iClk    (iClk),
    .iRst    (iRst),
    .iRxByte (iRxByte),
    .iRxDone (iRxDone),
    .oData   (oData),
    .oValid  (oValid),
    .iReady  (iReady),
    .oBusy   (oBusy),
    .oTimeout(oTimeout),
    .oOverrun(oOverrun),
    .oState  (oState)
  );

  // Clock and reset
  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic sendByte(input logic [7:0] b);
    iRxByte = b;
    iRxDone = 1'b1;
    tick();
    iRxDone = 1'b0;
    iRxByte = 8'h00;
  endtask

  task automatic runFrame(input vec_t v);
    exp_q.push_back(v.expWord);
    iReady = (v.hold == 0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) idle(v.gap);
      if (i == 3) checkVal("valid_before_last", oValid, 0);
      sendByte(v.bytes[31-8*i -: 8]);
      if (i == 0) checkVal("busy_collect", oBusy, 1);
    end
    checkVal("valid_latency", oValid, 1);
    checkVal("busy_in_hold", oBusy, 0);
    checkVal("frame_data", oData, v.expWord);
    for (int h = 0; h < v.hold; h++) begin
      tick();
      checkVal("hold_valid", oValid, 1);
      checkVal("hold_data", oData, v.expWord);
    end
    iReady = 1'b1;
    tick();
    iReady = 1'b0;
    checkVal("valid_drop", oValid, 0);
    checkVal("state_idle", oState, 0);
  endtask

  // Scoreboard and pulse monitors, sampled on the falling edge
  always @(negedge iClk) begin
    if (!iRst) begin
      if (oTimeout) timeoutCnt++;
      if (oOverrun) overrunCnt++;
      if (oValid && iReady) begin
        if (exp_q.size() == 0) begin
          checkVal("sb_unexpected_frame", oData, 32'hxxxx_xxxx);
        end else begin
          checkVal("sb_frame", oData, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    vecs[0] = '{bytes: 32'h12345678, gap: 99,  hold: 0,  expWord: 32'h12345678};
    vecs[1] = '{bytes: 32'hDEADBEEF, gap: 2,   hold: 50, expWord: 32'hDEADBEEF};
    vecs[2] = '{bytes: 32'h00000001, gap: 0,   hold: 0,  expWord: 32'h00000001};
    vecs[3] = '{bytes: 32'hA5C35A3C, gap: 399, hold: 1,  expWord: 32'hA5C35A3C};
    vecs[4] = '{bytes: 32'h80FF7F01, gap: 0,   hold: 0,  expWord: 32'h80FF7F01};

    iRst = 1'b1;
    iRxByte = 8'h00;
    iRxDone = 1'b0;
    iReady = 1'b0;
    repeat (3) @(posedge iClk);
    #1;
    checkVal("rst_data", oData, 0);
    checkVal("rst_valid", oValid, 0);
    checkVal("rst_busy", oBusy, 0);
    checkVal("rst_state", oState, 0);
    iRst = 1'b0;
    tick();

    // Table: plain frames, long hold, back-to-back, strobe at timer==399
    for (int k = 0; k < 5; k++) runFrame(vecs[k]);
    checkVal("no_timeout_table", timeoutCnt, 0);

    // Idle timeout after two bytes, then a clean frame
    sendByte(8'hAA);
    sendByte(8'hBB);
    idle(399);
    checkVal("tmo_not_early", oTimeout, 0);
    checkVal("tmo_busy_wait", oBusy, 1);
    tick();
    checkVal("tmo_pulse", oTimeout, 1);
    checkVal("tmo_busy_clear", oBusy, 0);
    tick();
    checkVal("tmo_single_pulse", oTimeout, 0);
    runFrame('{bytes: 32'h01020304, gap: 10, hold: 0, expWord: 32'h01020304});
    checkVal("tmo_count", timeoutCnt, 1);

    // Overrun while held, then a byte on the handshake edge
    exp_q.push_back(32'hC0FFEE11);
    sendByte(8'hC0);
    sendByte(8'hFF);
    sendByte(8'hEE);
    sendByte(8'h11);
    idle(3);
    checkVal("ovr_held_valid", oValid, 1);
    sendByte(8'hEE);
    checkVal("ovr_pulse", oOverrun, 1);
    checkVal("ovr_data_kept", oData, 32'hC0FFEE11);
    checkVal("ovr_valid_kept", oValid, 1);
    tick();
    checkVal("ovr_single_pulse", oOverrun, 0);
    iReady = 1'b1;
    exp_q.push_back(32'hEE010203);
    sendByte(8'hEE);
    iReady = 1'b0;
    checkVal("hs_byte_valid", oValid, 0);
    checkVal("hs_byte_busy", oBusy, 1);
    checkVal("hs_byte_no_ovr", oOverrun, 0);
    sendByte(8'h01);
    sendByte(8'h02);
    sendByte(8'h03);
    checkVal("hs_byte_frame_valid", oValid, 1);
    checkVal("hs_byte_frame_data", oData, 32'hEE010203);
    iReady = 1'b1;
    tick();
    iReady = 1'b0;
    checkVal("ovr_count", overrunCnt, 1);

    // Reset in the middle of a frame
    sendByte(8'h11);
    sendByte(8'h22);
    iRst = 1'b1;
    tick();
    checkVal("mid_rst_data", oData, 0);
    checkVal("mid_rst_valid", oValid, 0);
    checkVal("mid_rst_busy", oBusy, 0);
    checkVal("mid_rst_tmo", oTimeout, 0);
    checkVal("mid_rst_ovr", oOverrun, 0);
    checkVal("mid_rst_state", oState, 0);
    iRst = 1'b0;
    idle(450);
    checkVal("mid_rst_no_tmo", timeoutCnt, 1);
    runFrame('{bytes: 32'h9ABCDEF0, gap: 5, hold: 0, expWord: 32'h9ABCDEF0});

    idle(5);
    checkVal("sb_queue_empty", exp_q.size(), 0);
    checkVal("final_tmo_count", timeoutCnt, 1);
    checkVal("final_ovr_count", overrunCnt, 1);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
